slink_bist_tx_gen: RTL and testbench
====================================

Name: slink_bist_tx_gen

Overview:
- Second-generation S-Link BIST traffic generator.
- Drives packets into the link-layer TX through the sop / data_id / word_count / app_data / advance interface.
- Adds the following to the existing generator:
  - generic APP_DATA_WIDTH
  - PRBS31 in addition to PRBS9
  - a packet-count limit with a done flag
  - programmable idle gaps between packets
  - a live packet counter for software
- Sits beside the LL TX, muxed in place of application traffic when BIST is enabled.

Parameters:
- APP_DATA_WIDTH, 32, payload width in bits; must be a multiple of 8, range 8..256.
- APP_DATA_BYTES, APP_DATA_WIDTH/8, derived; do not override.
- PKT_CNT_WIDTH, 16, width of the packet limit and packet counter.
- GAP_WIDTH, 8, width of the inter-packet gap setting.

Ports:
- clk  in  1  block clock.
- reset_n  in  1  asynchronous active-low reset.
- swi_bist_en  in  1  enable, asynchronous to clk; synchronised internally through 2 flops.
- swi_bist_mode_payload  in  4  payload select: 0=0xAA, 1=0xCC, 2=0xF0, 3=COUNT, 4=PRBS9, 5=PRBS31, others=0xD0 fill.
- swi_bist_mode_wc  in  1  1 = sweep word_count.
- swi_bist_wc_min / swi_bist_wc_max  in  16  word_count sweep bounds.
- swi_bist_mode_di  in  1  1 = sweep data_id.
- swi_bist_di_min / swi_bist_di_max  in  8  data_id sweep bounds.
- swi_bist_seed  in  32  PRBS seed.
- swi_bist_pkt_limit  in  PKT_CNT_WIDTH  packets to send; 0 = unlimited.
- swi_bist_gap  in  GAP_WIDTH  idle cycles between packets.
- sop  out  1  packet header valid.
- data_id  out  8  packet data id.
- word_count  out  16  payload byte count.
- app_data  out  APP_DATA_WIDTH  payload word.
- advance  in  1  LL TX accepts the current beat.
- bist_active  out  1  state is neither IDLE nor DONE.
- bist_done  out  1  packet limit reached.
- bist_pkt_count  out  PKT_CNT_WIDTH  packets completed since start; saturates at all-ones.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state = IDLE.
  - All outputs and internal counters are 0, including the synchroniser flops.
- Registers and sampling:
  - All outputs are registered.
  - en_s is the synchronised enable; only en_s is used.
  - Configuration is sampled live; software changes it only while disabled.
- States: IDLE, SOP, PAYLOAD, GAP, DONE.
- IDLE:
  - Holds sop=0.
  - On en_s=1, next cycle:
    - sop=1, data_id=di_min, word_count=wc_min.
    - byte_count=APP_DATA_BYTES (17-bit).
    - pkt_count=0; PRBS seeded.
    - app_data = word 0 of the packet.
    - Go to SOP.
- SOP:
  - sop=1; outputs hold until advance.
  - The advance accepts the header and app_data together.
- PAYLOAD:
  - sop=0.
  - On advance: byte_count += APP_DATA_BYTES, and the next word is presented the cycle after.
- Packet end: advance while byte_count >= word_count, in either SOP or PAYLOAD. A word_count of 0 is therefore a single SOP beat.
- On packet end, the following all happen in the same cycle:
  - pkt_count increments.
  - data_id_next = mode_di ? (data_id==di_max ? di_min : data_id+1) : data_id. word_count_next follows the same rule with the wc bounds.
  - If min > max, the value increments modulo 2^width until it equals max.
- Next-state priority after packet end:
  1. limit != 0 and the new pkt_count == limit -> DONE.
  2. en_s=0 -> IDLE.
  3. gap != 0 -> GAP, with gap_cnt = gap.
  4. Otherwise -> SOP, with byte_count = APP_DATA_BYTES and app_data = word 0 of the next packet.
- Disable mid-packet: the current packet always completes; it is never truncated.
- GAP:
  - sop=0; gap_cnt decrements each cycle.
  - Exactly gap cycles with sop=0 occur between the final advance and sop=1.
  - en_s=0 during GAP -> IDLE.
- DONE:
  - sop=0, bist_done=1.
  - Stays in DONE until en_s=0, then IDLE; bist_done clears on leaving DONE.
  - bist_pkt_count holds its value until the next start.
- Payload content:
  - Fixed patterns: the byte pattern replicated across all bytes.
  - COUNT: word k of a packet, byte i = (k*APP_DATA_BYTES + i) mod 256; restarts at 0 for each packet.
- PRBS:
  - PRBS9 is x^9+x^5+1; PRBS31 is x^31+x^28+1.
  - Fibonacci LFSR, shifted left; new bit = XOR of the taps; each new bit is one output bit.
  - Bytes are filled LSB byte first, bit 0 first: 8*APP_DATA_BYTES bits per word, computed in a single cycle.
  - Seeding: seed[8:0] for PRBS9, seed[30:0] for PRBS31. An all-zero seed is replaced by all-ones.
  - The sequence is continuous across packets and gaps; it advances only on accepted beats.
- Stalls: advance=0 holds every output and internal state unchanged.

Test Plan:
- Stall and stop: APP_DATA_WIDTH=32, payload 0, wc 8 fixed, di 0x20, gap 0, limit 3, advance stalled 0 at random.
  - Each packet is a SOP beat then one PAYLOAD beat, data 0xAAAAAAAA.
  - Exactly 3 packets, then bist_done=1, bist_pkt_count=3, sop stays 0.
- COUNT: mode 3, wc 10.
  - Beats are 0x03020100 (sop=1), 0x07060504, 0x0B0A0908.
  - The third advance ends the packet; the next SOP shows 0x03020100.
- Gap timing: gap 3, advance tied to 1.
  - After each final advance, sop is 0 for exactly 3 cycles, then 1.
  - With gap 0, sop rises in the cycle immediately after the final advance.
- Sweeps: wc 4..6, di 0x20..0x21, both sweeps enabled, 4 packets.
  - word_count sequence 4,5,6,4.
  - data_id sequence 0x20,0x21,0x20,0x21.
- PRBS: mode 4 with seed 0x1FF and mode 5 with seed 0; compare against a reference LFSR model.
  - Every accepted word matches the model and continues across packet boundaries.
  - Seed 0 produces the same output as the all-ones seed.
- Disable and reset:
  - Deassert swi_bist_en mid-packet (wc 16) -> the remaining words are sent, then IDLE with sop=0 and bist_active=0.
  - Assert reset_n low mid-packet -> all outputs 0 immediately; restart behaves as from power-up.

Source files
------------

// File: rtl/slink_bist_tx_gen.sv
// slink_bist_tx_gen
//   BIST traffic generator for the S-Link link-layer TX. Emits a stream of
//   packets (header on sop, payload words on app_data) using the same
//   sop / data_id / word_count / app_data / advance handshake as application
//   traffic. It supports fixed, counting, PRBS9 and PRBS31 payloads, optional
//   data_id / word_count sweeps, a packet limit with a done flag, and
//   programmable idle gaps between packets.
// Ports:
//   clk, reset_n           clock, async active-low reset
//   swi_bist_*             software configuration (en is async, synchronised here)
//   sop/data_id/word_count/app_data  outputs to LL TX, held until advance
//   advance                LL TX accepts the current beat
//   bist_active/bist_done/bist_pkt_count  status for software
module slink_bist_tx_gen #(
  parameter int APP_DATA_WIDTH = 32,
  parameter int APP_DATA_BYTES = APP_DATA_WIDTH/8,
  parameter int PKT_CNT_WIDTH  = 16,
  parameter int GAP_WIDTH      = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      swi_bist_en,
  input  logic [3:0]                swi_bist_mode_payload,
  input  logic                      swi_bist_mode_wc,
  input  logic [15:0]               swi_bist_wc_min,
  input  logic [15:0]               swi_bist_wc_max,
  input  logic                      swi_bist_mode_di,
  input  logic [7:0]                swi_bist_di_min,
  input  logic [7:0]                swi_bist_di_max,
  input  logic [31:0]               swi_bist_seed,
  input  logic [PKT_CNT_WIDTH-1:0]  swi_bist_pkt_limit,
  input  logic [GAP_WIDTH-1:0]      swi_bist_gap,
  output logic                      sop,
  output logic [7:0]                data_id,
  output logic [15:0]               word_count,
  output logic [APP_DATA_WIDTH-1:0] app_data,
  input  logic                      advance,
  output logic                      bist_active,
  output logic                      bist_done,
  output logic [PKT_CNT_WIDTH-1:0]  bist_pkt_count
);

  typedef enum logic [2:0] {ST_IDLE, ST_SOP, ST_PAYLOAD, ST_GAP, ST_DONE} state_t;

  state_t                 state;
  logic                   en_meta, en_s;
  logic [16:0]            byte_count;   // bytes delivered including the current beat
  logic [GAP_WIDTH-1:0]   gap_cnt;
  logic [30:0]            lfsr;         // PRBS state after the word currently presented
  logic [7:0]             cnt_base;     // COUNT byte value for the next word

  logic                   is_prbs9;
  logic [30:0]            seed_state, lfsr_in, prbs_s;
  logic                   prbs_nb;
  logic [APP_DATA_WIDTH-1:0] prbs_word, gen_word;
  logic [7:0]             base_in, gen_base;
  logic                   in_pkt, pkt_end;
  logic [PKT_CNT_WIDTH-1:0] pkt_next;
  logic                   limit_hit;
  logic [7:0]             di_next;
  logic [15:0]            wc_next;
  logic                   unused_seed_msb;

  assign unused_seed_msb = swi_bist_seed[31];

  assign is_prbs9 = (swi_bist_mode_payload == 4'd4);

  // All-zero seeds would lock the LFSR, so they are replaced by all-ones.
  always_comb begin
    seed_state = '0;
    if (is_prbs9)
      seed_state[8:0] = (swi_bist_seed[8:0] == 9'd0) ? 9'h1FF : swi_bist_seed[8:0];
    else
      seed_state = (swi_bist_seed[30:0] == 31'd0) ? 31'h7FFF_FFFF : swi_bist_seed[30:0];
  end

  assign in_pkt  = (state == ST_SOP) || (state == ST_PAYLOAD);
  assign pkt_end = in_pkt && (byte_count >= {1'b0, word_count});

  // Word generation: word 0 of a packet is built from the seed (from IDLE) or
  // the running LFSR; COUNT restarts at 0 for every new packet.
  assign lfsr_in = (state == ST_IDLE) ? seed_state : lfsr;
  assign base_in = (in_pkt && !pkt_end) ? cnt_base : 8'd0;
  assign gen_base = base_in + 8'(APP_DATA_BYTES);

  always_comb begin
    prbs_s    = lfsr_in;
    prbs_nb   = 1'b0;
    prbs_word = '0;
    for (int b = 0; b < APP_DATA_WIDTH; b++) begin
      if (is_prbs9) begin
        prbs_nb = prbs_s[8] ^ prbs_s[4];
        prbs_s  = {22'd0, prbs_s[7:0], prbs_nb};
      end else begin
        prbs_nb = prbs_s[30] ^ prbs_s[27];
        prbs_s  = {prbs_s[29:0], prbs_nb};
      end
      prbs_word[b] = prbs_nb;
    end
  end

  always_comb begin
    gen_word = {APP_DATA_BYTES{8'hD0}};
    case (swi_bist_mode_payload)
      4'd0: gen_word = {APP_DATA_BYTES{8'hAA}};
      4'd1: gen_word = {APP_DATA_BYTES{8'hCC}};
      4'd2: gen_word = {APP_DATA_BYTES{8'hF0}};
      4'd3: for (int i = 0; i < APP_DATA_BYTES; i++) gen_word[8*i +: 8] = base_in + 8'(i);
      4'd4, 4'd5: gen_word = prbs_word;
      default: gen_word = {APP_DATA_BYTES{8'hD0}};
    endcase
  end

  assign pkt_next  = (&bist_pkt_count) ? bist_pkt_count : bist_pkt_count + PKT_CNT_WIDTH'(1);
  assign limit_hit = (swi_bist_pkt_limit != '0) && (pkt_next == swi_bist_pkt_limit);

  // Sweeps wrap back to min only on an exact match with max, so min > max
  // simply counts through the modulo wrap.
  assign di_next = !swi_bist_mode_di ? data_id :
                   (data_id == swi_bist_di_max) ? swi_bist_di_min : data_id + 8'd1;
  assign wc_next = !swi_bist_mode_wc ? word_count :
                   (word_count == swi_bist_wc_max) ? swi_bist_wc_min : word_count + 16'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      en_meta        <= 1'b0;
      en_s           <= 1'b0;
      byte_count     <= '0;
      gap_cnt        <= '0;
      lfsr           <= '0;
      cnt_base       <= '0;
      sop            <= 1'b0;
      data_id        <= '0;
      word_count     <= '0;
      app_data       <= '0;
      bist_active    <= 1'b0;
      bist_done      <= 1'b0;
      bist_pkt_count <= '0;
    end else begin
      en_meta <= swi_bist_en;
      en_s    <= en_meta;
      case (state)
        ST_IDLE: begin
          sop <= 1'b0;
          if (en_s) begin
            state          <= ST_SOP;
            sop            <= 1'b1;
            data_id        <= swi_bist_di_min;
            word_count     <= swi_bist_wc_min;
            byte_count     <= 17'(APP_DATA_BYTES);
            bist_pkt_count <= '0;
            app_data       <= gen_word;
            lfsr           <= prbs_s;
            cnt_base       <= gen_base;
            bist_active    <= 1'b1;
            bist_done      <= 1'b0;
          end
        end
        ST_SOP, ST_PAYLOAD: begin
          if (advance) begin
            if (pkt_end) begin
              bist_pkt_count <= pkt_next;
              data_id        <= di_next;
              word_count     <= wc_next;
              sop            <= 1'b0;
              if (limit_hit) begin
                state       <= ST_DONE;
                bist_done   <= 1'b1;
                bist_active <= 1'b0;
              end else if (!en_s) begin
                state       <= ST_IDLE;
                bist_active <= 1'b0;
              end else if (swi_bist_gap != '0) begin
                state   <= ST_GAP;
                gap_cnt <= swi_bist_gap;
              end else begin
                state      <= ST_SOP;
                sop        <= 1'b1;
                byte_count <= 17'(APP_DATA_BYTES);
                app_data   <= gen_word;
                lfsr       <= prbs_s;
                cnt_base   <= gen_base;
              end
            end else begin
              state      <= ST_PAYLOAD;
              sop        <= 1'b0;
              byte_count <= byte_count + 17'(APP_DATA_BYTES);
              app_data   <= gen_word;
              lfsr       <= prbs_s;
              cnt_base   <= gen_base;
            end
          end
        end
        ST_GAP: begin
          if (!en_s) begin
            state       <= ST_IDLE;
            bist_active <= 1'b0;
          end else if (gap_cnt == GAP_WIDTH'(1)) begin
            state      <= ST_SOP;
            sop        <= 1'b1;
            byte_count <= 17'(APP_DATA_BYTES);
            app_data   <= gen_word;
            lfsr       <= prbs_s;
            cnt_base   <= gen_base;
          end else begin
            gap_cnt <= gap_cnt - GAP_WIDTH'(1);
          end
        end
        ST_DONE: begin
          sop <= 1'b0;
          if (!en_s) begin
            state     <= ST_IDLE;
            bist_done <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slink_bist_tx_gen.sv
// Testbench for slink_bist_tx_gen: directed scenarios with randomized advance
// stalls, checked against a packet-level reference model (sweep rules,
// pattern/COUNT formulas, PRBS as a bit recurrence over a history queue).
module tb_slink_bist_tx_gen;
  localparam int W  = 32;
  localparam int B  = W/8;
  localparam int PW = 16;
  localparam int GW = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          swi_bist_en = 1'b0;
  logic [3:0]    swi_bist_mode_payload = '0;
  logic          swi_bist_mode_wc = 1'b0;
  logic [15:0]   swi_bist_wc_min = '0, swi_bist_wc_max = '0;
  logic          swi_bist_mode_di = 1'b0;
  logic [7:0]    swi_bist_di_min = '0, swi_bist_di_max = '0;
  logic [31:0]   swi_bist_seed = '0;
  logic [PW-1:0] swi_bist_pkt_limit = '0;
  logic [GW-1:0] swi_bist_gap = '0;
  logic          advance = 1'b0;
  logic          sop, bist_active, bist_done;
  logic [7:0]    data_id;
  logic [15:0]   word_count;
  logic [W-1:0]  app_data;
  logic [PW-1:0] bist_pkt_count;

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [7:0]  m_di;
  logic [15:0] m_wc;
  int          m_pkt;
  bit          hist[$];
  int          m_len, m_tap;

  slink_bist_tx_gen #(.APP_DATA_WIDTH(W), .PKT_CNT_WIDTH(PW), .GAP_WIDTH(GW)) dut (
    .clk(clk), .reset_n(reset_n), .swi_bist_en(swi_bist_en),
    .swi_bist_mode_payload(swi_bist_mode_payload),
    .swi_bist_mode_wc(swi_bist_mode_wc), .swi_bist_wc_min(swi_bist_wc_min),
    .swi_bist_wc_max(swi_bist_wc_max), .swi_bist_mode_di(swi_bist_mode_di),
    .swi_bist_di_min(swi_bist_di_min), .swi_bist_di_max(swi_bist_di_max),
    .swi_bist_seed(swi_bist_seed), .swi_bist_pkt_limit(swi_bist_pkt_limit),
    .swi_bist_gap(swi_bist_gap), .sop(sop), .data_id(data_id),
    .word_count(word_count), .app_data(app_data), .advance(advance),
    .bist_active(bist_active), .bist_done(bist_done), .bist_pkt_count(bist_pkt_count)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // PRBS as the recurrence x[n] = x[n-L] ^ x[n-T]; queue front is the oldest bit.
  task automatic model_seed();
    logic [30:0] s;
    hist.delete();
    if (swi_bist_mode_payload == 4'd4) begin
      m_len = 9; m_tap = 5;
      s = (swi_bist_seed[8:0] == 9'd0) ? 31'h1FF : {22'd0, swi_bist_seed[8:0]};
    end else begin
      m_len = 31; m_tap = 28;
      s = (swi_bist_seed[30:0] == 31'd0) ? 31'h7FFF_FFFF : swi_bist_seed[30:0];
    end
    for (int j = m_len - 1; j >= 0; j--) hist.push_back(s[j]);
  endtask

  function automatic bit next_bit();
    bit nb;
    nb = hist[0] ^ hist[m_len - m_tap];
    void'(hist.pop_front());
    hist.push_back(nb);
    return nb;
  endfunction

  function automatic logic [W-1:0] exp_word(input int k);
    logic [W-1:0] w;
    logic [7:0]   p;
    case (swi_bist_mode_payload)
      4'd0: p = 8'hAA;
      4'd1: p = 8'hCC;
      4'd2: p = 8'hF0;
      default: p = 8'hD0;
    endcase
    w = {B{p}};
    if (swi_bist_mode_payload == 4'd3)
      for (int i = 0; i < B; i++) w[8*i +: 8] = 8'((k*B + i) % 256);
    if (swi_bist_mode_payload == 4'd4 || swi_bist_mode_payload == 4'd5)
      for (int b = 0; b < W; b++) w[b] = next_bit();
    return w;
  endfunction

  task automatic start_bist();
    m_di  = swi_bist_di_min;
    m_wc  = swi_bist_wc_min;
    m_pkt = 0;
    if (swi_bist_mode_payload == 4'd4 || swi_bist_mode_payload == 4'd5) model_seed();
    swi_bist_en = 1'b1;
  endtask

  task automatic stop_bist();
    swi_bist_en = 1'b0;
    advance = 1'b0;
    repeat (5) @(negedge clk);
    chk("stop_active", bist_active, 0);
    chk("stop_done", bist_done, 0);
    chk("stop_sop", sop, 0);
  endtask

  // Runs npkts packets, called and returning at a negedge.
  task automatic run_traffic(input int npkts, input int stall_pct, input bit dis_mid);
    int g, nb;
    bit acc;
    logic [W-1:0] ew;
    for (int p = 0; p < npkts; p++) begin
      g = 0;
      while (sop !== 1'b1 && g < 300) begin
        advance = 1'b0;
        @(negedge clk);
        g++;
      end
      if (p > 0) chk("gap_len", g, swi_bist_gap);
      else       chk("first_sop", sop, 1);
      nb = (m_wc == 16'd0) ? 1 : (int'(m_wc) + B - 1) / B;
      for (int k = 0; k < nb; k++) begin
        ew  = exp_word(k);
        acc = 1'b0;
        while (!acc) begin
          chk("sop", sop, (k == 0));
          chk("data_id", data_id, m_di);
          chk("word_count", word_count, m_wc);
          chk("app_data", app_data, ew);
          if (dis_mid && k == 1) swi_bist_en = 1'b0;
          acc = ($urandom_range(99) >= stall_pct);
          advance = acc;
          @(negedge clk);
        end
      end
      advance = 1'b0;
      m_pkt++;
      m_di = !swi_bist_mode_di ? m_di : (m_di == swi_bist_di_max) ? swi_bist_di_min : m_di + 8'd1;
      m_wc = !swi_bist_mode_wc ? m_wc : (m_wc == swi_bist_wc_max) ? swi_bist_wc_min : m_wc + 16'd1;
      chk("pkt_count", bist_pkt_count, m_pkt);
      if (swi_bist_pkt_limit != 0 && m_pkt == int'(swi_bist_pkt_limit)) begin
        chk("done_set", bist_done, 1);
        chk("done_active", bist_active, 0);
        chk("done_sop", sop, 0);
      end else if (dis_mid) begin
        chk("dis_active", bist_active, 0);
        chk("dis_sop", sop, 0);
      end else begin
        chk("run_done_low", bist_done, 0);
        chk("run_active", bist_active, 1);
      end
    end
  endtask

  task automatic cfg(input logic [3:0] mode, input logic [15:0] wmin, input logic [15:0] wmax,
                     input logic mwc, input logic [7:0] dmin, input logic [7:0] dmax,
                     input logic mdi, input logic [PW-1:0] lim, input logic [GW-1:0] gap,
                     input logic [31:0] seed);
    swi_bist_mode_payload = mode;
    swi_bist_wc_min = wmin; swi_bist_wc_max = wmax; swi_bist_mode_wc = mwc;
    swi_bist_di_min = dmin; swi_bist_di_max = dmax; swi_bist_mode_di = mdi;
    swi_bist_pkt_limit = lim; swi_bist_gap = gap; swi_bist_seed = seed;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_sop"}, sop, 0);
    chk({tag, "_di"}, data_id, 0);
    chk({tag, "_wc"}, word_count, 0);
    chk({tag, "_data"}, app_data, 0);
    chk({tag, "_active"}, bist_active, 0);
    chk({tag, "_done"}, bist_done, 0);
    chk({tag, "_cnt"}, bist_pkt_count, 0);
  endtask

  initial begin
    int g;
    // power-up reset
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // stall and stop: fixed 0xAA, 2 beats per packet, limit 3
    cfg(4'd0, 16'd8, 16'd8, 1'b0, 8'h20, 8'h20, 1'b0, 16'd3, 8'd0, 32'd0);
    start_bist();
    run_traffic(3, 40, 1'b0);
    repeat (4) @(negedge clk);
    chk("done_hold", bist_done, 1);
    chk("done_hold_sop", sop, 0);
    chk("done_hold_cnt", bist_pkt_count, 3);
    stop_bist();
    chk("cnt_after_stop", bist_pkt_count, 3);

    // COUNT payload, wc 10
    cfg(4'd3, 16'd10, 16'd10, 1'b0, 8'h11, 8'h11, 1'b0, 16'd2, 8'd0, 32'd0);
    start_bist();
    run_traffic(2, 0, 1'b0);
    stop_bist();

    // gap 3 with default 0xD0 fill, advance always 1
    cfg(4'd9, 16'd8, 16'd8, 1'b0, 8'h30, 8'h30, 1'b0, 16'd3, 8'd3, 32'd0);
    start_bist();
    run_traffic(3, 0, 1'b0);
    stop_bist();

    // sweeps on both fields
    cfg(4'd2, 16'd4, 16'd6, 1'b1, 8'h20, 8'h21, 1'b1, 16'd4, 8'd0, 32'd0);
    start_bist();
    run_traffic(4, 25, 1'b0);
    stop_bist();

    // PRBS9, PRBS31 with zero seed
    cfg(4'd4, 16'd12, 16'd12, 1'b0, 8'h05, 8'h05, 1'b0, 16'd3, 8'd2, 32'h1FF);
    start_bist();
    run_traffic(3, 30, 1'b0);
    stop_bist();
    cfg(4'd5, 16'd8, 16'd8, 1'b0, 8'h06, 8'h06, 1'b0, 16'd3, 8'd1, 32'd0);
    start_bist();
    run_traffic(3, 30, 1'b0);
    stop_bist();
    cfg(4'd5, 16'd4, 16'd4, 1'b0, 8'h07, 8'h07, 1'b0, 16'd4, 8'd0, 32'($urandom));
    start_bist();
    run_traffic(4, 20, 1'b0);
    stop_bist();

    // disable mid-packet, wc 16, unlimited
    cfg(4'd1, 16'd16, 16'd16, 1'b0, 8'h40, 8'h40, 1'b0, 16'd0, 8'd0, 32'd0);
    start_bist();
    run_traffic(1, 0, 1'b1);
    repeat (3) @(negedge clk);
    chk("dis_idle_sop", sop, 0);
    chk("dis_idle_active", bist_active, 0);

    // reset mid-packet
    cfg(4'd1, 16'd16, 16'd16, 1'b0, 8'h50, 8'h50, 1'b0, 16'd0, 8'd0, 32'd0);
    start_bist();
    g = 0;
    while (sop !== 1'b1 && g < 50) begin @(negedge clk); g++; end
    chk("rst_pre_sop", sop, 1);
    advance = 1'b1;
    @(negedge clk);
    advance = 1'b0;
    #2 reset_n = 1'b0;
    #1 chk_zero("midrst");
    @(negedge clk);
    @(negedge clk);
    cfg(4'd3, 16'd8, 16'd8, 1'b0, 8'h60, 8'h60, 1'b0, 16'd1, 8'd0, 32'd0);
    start_bist();
    reset_n = 1'b1;
    run_traffic(1, 10, 1'b0);
    stop_bist();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
